pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, program-counter width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0080, PC value loaded on exception or misaligned redirect.
REQ-004 Parameter INC, default 4, sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, minimum 2.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 stall  in  1  hold PC and stack this cycle.
REQ-009 exc  in  1  exception request; redirects to EXC_VECTOR.
REQ-010 ret  in  1  return; next PC popped from stack.
REQ-011 jmp  in  1  absolute jump to jmp_target.
REQ-012 call  in  1  qualifies jmp; pushes return address.
REQ-013 jmp_target  in  WIDTH  absolute jump address.
REQ-014 br_taken  in  1  take relative branch.
REQ-015 br_offset  in  WIDTH  signed two's-complement byte offset from current PC.
REQ-016 pc_out  out  WIDTH  registered current PC.
REQ-017 pc_plus  out  WIDTH  combinational pc_out + INC.
REQ-018 misalign  out  1  registered one-cycle pulse: last redirect target misaligned.
REQ-019 ras_empty  out  1  stack holds zero entries.
REQ-020 ras_full  out  1  stack holds RAS_DEPTH entries.
REQ-021 ras_err  out  1  registered one-cycle pulse: push on full (overwrite) or pop on empty.

Function
REQ-022 Next-PC priority SHALL be: exc > stall > ret > jmp > br_taken > sequential (pc_out + INC).
REQ-023 exc SHALL load EXC_VECTOR regardless of stall; stack unchanged.
REQ-024 stall without exc SHALL hold pc_out and all stack state; misalign and ras_err SHALL be 0 that cycle.
REQ-025 ret SHALL load the top stack entry and pop it; lower-priority inputs ignored that cycle.
REQ-026 ret on empty stack SHALL load pc_out + INC, leave the stack empty, and pulse ras_err.
REQ-027 jmp SHALL load jmp_target; with call asserted it SHALL push pc_out + INC.
REQ-028 call without jmp SHALL have no effect.
REQ-029 Push on full stack SHALL overwrite the oldest entry (circular buffer), keep count at RAS_DEPTH, and pulse ras_err.
REQ-030 br_taken SHALL load pc_out + br_offset.
REQ-031 All PC arithmetic SHALL wrap modulo 2^WIDTH without flag.
REQ-032 If a ret, jmp, or branch target has bits [1:0] != 0, PC SHALL load EXC_VECTOR instead, misalign SHALL pulse next cycle, and any accompanying push/pop SHALL still occur.
REQ-033 Sequential and exc targets SHALL NOT be alignment-checked.
REQ-034 Latency: every redirect SHALL appear on pc_out one cycle after the requesting edge; no bubbles are inserted.
REQ-035 ras_empty and ras_full SHALL derive from a registered count in 0..RAS_DEPTH.

Reset
REQ-036 reset low SHALL immediately set pc_out = RESET_VECTOR, stack count = 0, misalign = 0, ras_err = 0, regardless of clk.
REQ-037 reset low mid-stall or mid-redirect SHALL discard the pending operation; first update after release uses the inputs at that edge.

Verification
REQ-038 Release reset, no requests, 3 edges -> pc_out 0, 4, 8, C; ras_empty = 1.
REQ-039 At pc 0x100: jmp+call to 0x200, then ret -> pc_out 0x200 then 0x104; ras_empty = 1 after.
REQ-040 RAS_DEPTH = 4: five jmp+call pushes from pc 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_err pulses on 5th; four rets return 0x54, 0x44, 0x34, 0x24; fifth ret -> ras_err, PC + 4.
REQ-041 stall with br_taken held 3 cycles, then exc with stall -> pc_out frozen, then 0x80.
REQ-042 br_taken, br_offset = 0x2 at pc 0x40 -> pc_out 0x80, misalign = 1 for one cycle; br_offset = 0xFFFF_FFF8 at pc 0x4 -> 0xFFFF_FFFC.
REQ-043 reset pulsed low between edges after a push -> pc_out = RESET_VECTOR immediately, ras_empty = 1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection with exception, stall, return,
// jump/call and relative branch, plus a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int unsigned       INC          = 4,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic             ret,
  input  logic             jmp,
  input  logic             call,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_offset,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic             misalign,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_EXC,
    SRC_HOLD,
    SRC_RET,
    SRC_RET_EMPTY,
    SRC_JMP,
    SRC_BR
  } src_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic             ras_err_q, ras_err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] top_ptr;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  src_e             src;
  logic [WIDTH-1:0] target;
  logic             checked;
  logic             push;
  logic             pop;
  logic             stack_empty;
  logic             stack_full;

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == DEPTH_C);
  assign top_ptr     = wr_ptr_q - PTR_W'(1);

  // Priority decode: exc > stall > ret > jmp > br_taken > sequential.
  always_comb begin
    src = SRC_SEQ;
    if (exc)           src = SRC_EXC;
    else if (stall)    src = SRC_HOLD;
    else if (ret)      src = stack_empty ? SRC_RET_EMPTY : SRC_RET;
    else if (jmp)      src = SRC_JMP;
    else if (br_taken) src = SRC_BR;
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    target     = pc_q + INC_W;
    checked    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    ras_err_d  = 1'b0;
    misalign_d = 1'b0;
    pc_d       = pc_q;

    unique case (src)
      SRC_RET: begin
        target  = ras_mem[top_ptr];
        checked = 1'b1;
        pop     = 1'b1;
      end
      SRC_RET_EMPTY: begin
        ras_err_d = 1'b1;
      end
      SRC_JMP: begin
        target    = jmp_target;
        checked   = 1'b1;
        push      = call;
        ras_err_d = call && stack_full;
      end
      SRC_BR: begin
        target  = pc_q + br_offset;
        checked = 1'b1;
      end
      default: ;
    endcase

    unique case (src)
      SRC_EXC:  pc_d = EXC_VECTOR;
      SRC_HOLD: pc_d = pc_q;
      default: begin
        // A misaligned redirect traps, but its push/pop still takes effect.
        misalign_d = checked && (target[1:0] != 2'b00);
        pc_d       = misalign_d ? EXC_VECTOR : target;
      end
    endcase
  end

  // Full stack overwrites the oldest slot, which is where wr_ptr already points.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = stack_full ? count_q : count_q + CNT_W'(1);
    end else if (pop) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      ras_err_q  <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      ras_err_q  <= ras_err_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; count_q gates every read,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) ras_mem[wr_ptr_q] <= pc_q + INC_W;
  end

  assign pc_out    = pc_q;
  assign pc_plus   = pc_q + INC_W;
  assign misalign  = misalign_q;
  assign ras_err   = ras_err_q;
  assign ras_empty = stack_empty;
  assign ras_full  = stack_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected state into a
// scoreboard queue, a separate monitor pops and compares after each update.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, exc, ret, jmp, call, br_taken;
  logic [31:0] jmp_target, br_offset;
  logic [31:0] pc_out, pc_plus;
  logic        misalign, ras_empty, ras_full, ras_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        mis;
    logic        err;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .exc        (exc),
    .ret        (ret),
    .jmp        (jmp),
    .call       (call),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .pc_out     (pc_out),
    .pc_plus    (pc_plus),
    .misalign   (misalign),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_err    (ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_state(input string name, input logic [31:0] pc, input logic mis,
                              input logic err, input logic empty, input logic full);
    exp_t e;
    e.name  = name;
    e.pc    = pc;
    e.mis   = mis;
    e.err   = err;
    e.empty = empty;
    e.full  = full;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input logic s, input logic x, input logic r, input logic j,
                        input logic c, input logic [31:0] tgt, input logic b,
                        input logic [31:0] off);
    stall = s; exc = x; ret = r; jmp = j; call = c;
    jmp_target = tgt; br_taken = b; br_offset = off;
  endtask

  // Called at a falling edge: drive inputs, record the state expected after
  // the next rising edge, then move on to the following falling edge.
  task automatic go(input string name, input logic s, input logic x, input logic r,
                    input logic j, input logic c, input logic [31:0] tgt, input logic b,
                    input logic [31:0] off, input logic [31:0] pc, input logic mis,
                    input logic err, input logic empty, input logic full);
    set_in(s, x, r, j, c, tgt, b, off);
    expect_state(name, pc, mis, err, empty, full);
    @(negedge clk);
  endtask

  // Monitor: the DUT presents new state after each rising edge and immediately
  // on reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.name, ".pc"},      pc_out,           e.pc);
        check({e.name, ".pc_plus"}, pc_plus,          e.pc + 32'd4);
        check({e.name, ".mis"},     32'(misalign),    32'(e.mis));
        check({e.name, ".err"},     32'(ras_err),     32'(e.err));
        check({e.name, ".empty"},   32'(ras_empty),   32'(e.empty));
        check({e.name, ".full"},    32'(ras_full),    32'(e.full));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    reset = 1'b1;
    expect_state("reset", 32'h0, 0, 0, 1, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    //  name          s x r j c target        b offset        pc            mis err emp full
    go("seq1",        0,0,0,0,0, 32'h0,        0,32'h0,        32'h4,        0,0,1,0);
    go("seq2",        0,0,0,0,0, 32'h0,        0,32'h0,        32'h8,        0,0,1,0);
    go("seq3",        0,0,0,0,0, 32'h0,        0,32'h0,        32'hC,        0,0,1,0);
    go("jmp100",      0,0,0,1,0, 32'h100,      0,32'h0,        32'h100,      0,0,1,0);
    go("call200",     0,0,0,1,1, 32'h200,      0,32'h0,        32'h200,      0,0,0,0);
    go("ret104",      0,0,1,0,0, 32'h0,        0,32'h0,        32'h104,      0,0,1,0);
    go("call_nojmp",  0,0,0,0,1, 32'h300,      0,32'h0,        32'h108,      0,0,1,0);

    go("jmp10",       0,0,0,1,0, 32'h10,       0,32'h0,        32'h10,       0,0,1,0);
    go("push1",       0,0,0,1,1, 32'h20,       0,32'h0,        32'h20,       0,0,0,0);
    go("push2",       0,0,0,1,1, 32'h30,       0,32'h0,        32'h30,       0,0,0,0);
    go("push3",       0,0,0,1,1, 32'h40,       0,32'h0,        32'h40,       0,0,0,0);
    go("push4",       0,0,0,1,1, 32'h50,       0,32'h0,        32'h50,       0,0,0,1);
    go("push5_ovf",   0,0,0,1,1, 32'h60,       0,32'h0,        32'h60,       0,1,0,1);
    go("pop54",       0,0,1,0,0, 32'h0,        0,32'h0,        32'h54,       0,0,0,0);
    go("pop44",       0,0,1,0,0, 32'h0,        0,32'h0,        32'h44,       0,0,0,0);
    go("pop34",       0,0,1,0,0, 32'h0,        0,32'h0,        32'h34,       0,0,0,0);
    go("pop24",       0,0,1,0,0, 32'h0,        0,32'h0,        32'h24,       0,0,1,0);
    go("pop_empty",   0,0,1,0,0, 32'h0,        0,32'h0,        32'h28,       0,1,1,0);
    go("after_err",   0,0,0,0,0, 32'h0,        0,32'h0,        32'h2C,       0,0,1,0);

    go("call_mis",    0,0,0,1,1, 32'h202,      0,32'h0,        32'h80,       1,0,0,0);
    go("ret_after",   0,0,1,0,0, 32'h0,        0,32'h0,        32'h30,       0,0,1,0);

    go("stall_a",     1,0,1,0,0, 32'h0,        1,32'h10,       32'h30,       0,0,1,0);
    go("stall_b",     1,0,0,0,0, 32'h0,        1,32'h10,       32'h30,       0,0,1,0);
    go("stall_c",     1,0,0,1,1, 32'h202,      1,32'h10,       32'h30,       0,0,1,0);
    go("exc_stall",   1,1,0,0,0, 32'h0,        1,32'h10,       32'h80,       0,0,1,0);

    go("jmp40",       0,0,0,1,0, 32'h40,       0,32'h0,        32'h40,       0,0,1,0);
    go("br_mis",      0,0,0,0,0, 32'h0,        1,32'h2,        32'h80,       1,0,1,0);
    go("after_mis",   0,0,0,0,0, 32'h0,        0,32'h0,        32'h84,       0,0,1,0);
    go("jmp4",        0,0,0,1,0, 32'h4,        0,32'h0,        32'h4,        0,0,1,0);
    go("br_back",     0,0,0,0,0, 32'h0,        1,32'hFFFF_FFF8,32'hFFFF_FFFC,0,0,1,0);
    go("seq_wrap",    0,0,0,0,0, 32'h0,        0,32'h0,        32'h0,        0,0,1,0);
    go("exc_over_jmp",0,1,0,1,1, 32'h300,      0,32'h0,        32'h80,       0,0,1,0);

    go("jmp0",        0,0,0,1,0, 32'h0,        0,32'h0,        32'h0,        0,0,1,0);
    go("push_mis",    0,0,0,1,1, 32'h102,      0,32'h0,        32'h80,       1,0,0,0);

    // Reset pulsed between edges with a redirect pending on the inputs.
    set_in(0, 0, 0, 1, 1, 32'h500, 0, 32'h0);
    #2;
    expect_state("mid_reset", 32'h0, 0, 0, 1, 0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    expect_state("post_reset", 32'h500, 0, 0, 0, 0);
    @(negedge clk);
    go("post_ret",    0,0,1,0,0, 32'h0,        0,32'h0,        32'h4,        0,0,1,0);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
